inexrecur_stack: RTL

- Parametrised work store for inexact-search recursion entries. Each entry is a packed InexRecur record {i, z, k, l} plus its state word.
- Replaces the paired fixed-depth regfile_InexRecur / regfile_state with one store that has push/pop handshakes and a selectable LIFO (depth-first) or FIFO (breadth-first) discipline.
- Sits between accelerator_fsm and the host preload path.
- Adds occupancy, high-water mark, sticky overflow/underflow, and a random-read debug port.

---
 rtl/inexrecur_stack_pkg.sv | 37 +++
 rtl/inexrecur_stack_if.sv | 35 +++
 rtl/inexrecur_stack_ram.sv | 51 +++++
 rtl/inexrecur_stack.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/inexrecur_stack_pkg.sv
// Shared definitions for the inexact-search recursion work store.
// Holds the InexRecur record layout (four byte fields i/z/k/l, i in the MSB
// byte), the default state-word width, and the LIFO/FIFO discipline codes.
package inexrecur_stack_pkg;

    localparam int FIELD_W      = 8;
    localparam int REC_W        = 4 * FIELD_W;
    localparam int I_OFS        = 24;
    localparam int Z_OFS        = 16;
    localparam int K_OFS        = 8;
    localparam int L_OFS        = 0;
    localparam int STATE_WORD_W = 18;

    localparam int MODE_LIFO = 0;
    localparam int MODE_FIFO = 1;

    typedef struct packed {
        logic [FIELD_W-1:0] i;
        logic [FIELD_W-1:0] z;
        logic [FIELD_W-1:0] k;
        logic [FIELD_W-1:0] l;
    } inex_recur_t;

    // Build a record from its four byte fields.
    function automatic inex_recur_t pack_rec(input logic [FIELD_W-1:0] i,
                                             input logic [FIELD_W-1:0] z,
                                             input logic [FIELD_W-1:0] k,
                                             input logic [FIELD_W-1:0] l);
        inex_recur_t r;
        r.i = i;
        r.z = z;
        r.k = k;
        r.l = l;
        return r;
    endfunction

endpackage

// File: rtl/inexrecur_stack_if.sv
// Push / pop / random-read bundle of the recursion work store.
// master: the requester (accelerator FSM or host preload path).
// slave : the store itself.
interface inexrecur_stack_if #(
    parameter int DATA_W  = 32,
    parameter int STATE_W = 18,
    parameter int ADDR_W  = 4
);
    logic               push_valid_i;
    logic               push_ready_o;
    logic [DATA_W-1:0]  push_data_i;
    logic [STATE_W-1:0] push_state_i;
    logic               pop_req_i;
    logic               pop_ready_o;
    logic               pop_valid_o;
    logic [DATA_W-1:0]  pop_data_o;
    logic [STATE_W-1:0] pop_state_o;
    logic               rd_en_i;
    logic [ADDR_W-1:0]  rd_addr_i;
    logic [DATA_W-1:0]  rd_data_o;
    logic [STATE_W-1:0] rd_state_o;
    logic               rd_valid_o;

    modport master (
        output push_valid_i, push_data_i, push_state_i, pop_req_i, rd_en_i, rd_addr_i,
        input  push_ready_o, pop_ready_o, pop_valid_o, pop_data_o, pop_state_o,
               rd_data_o, rd_state_o, rd_valid_o
    );

    modport slave (
        input  push_valid_i, push_data_i, push_state_i, pop_req_i, rd_en_i, rd_addr_i,
        output push_ready_o, pop_ready_o, pop_valid_o, pop_data_o, pop_state_o,
               rd_data_o, rd_state_o, rd_valid_o
    );
endinterface

// File: rtl/inexrecur_stack_ram.sv
// Entry storage: one write port, two registered read ports (pop and random).
// Read-during-write of the same slot returns the old contents. Storage is
// not reset; only the read registers are.
// Ports: clk, rst_n, wr_en_i/wr_addr_i/wr_data_i, a_en_i/a_addr_i/a_data_o,
//        b_en_i/b_addr_i/b_data_o.
module inexrecur_stack_ram #(
    parameter int WIDTH  = 50,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              a_en_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    output logic [WIDTH-1:0]  a_data_o,
    input  logic              b_en_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    output logic [WIDTH-1:0]  b_data_o
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] a_data_r;
    logic [WIDTH-1:0] b_data_r;

    // Storage array write
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_r[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read ports; hold their value when not enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_data_r <= '0;
            b_data_r <= '0;
        end else begin
            if (a_en_i) begin
                a_data_r <= mem_r[a_addr_i];
            end
            if (b_en_i) begin
                b_data_r <= mem_r[b_addr_i];
            end
        end
    end

    assign a_data_o = a_data_r;
    assign b_data_o = b_data_r;
endmodule

// File: rtl/inexrecur_stack.sv
// Work store for inexact-search recursion entries ({i,z,k,l} record plus a
// state word) with LIFO (MODE=0) or FIFO (MODE=1) discipline.
// Ports: clk, rst_n (async active-low), clear_i (synchronous flush),
//        bus (push/pop/random-read handshakes), count_o, hwm_o,
//        overflow_o / underflow_o (sticky).
module inexrecur_stack
    import inexrecur_stack_pkg::*;
#(
    parameter int DATA_W  = REC_W,
    parameter int STATE_W = STATE_WORD_W,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int MODE    = MODE_LIFO
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    inexrecur_stack_if.slave     bus,
    output logic [ADDR_W:0]      count_o,
    output logic [ADDR_W:0]      hwm_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);
    localparam int ENT_W = DATA_W + STATE_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0]     count_r, count_next_s, hwm_r;
    logic                overflow_r, underflow_r, pop_valid_r, rd_valid_r;
    logic                bypass_r;
    logic [DATA_W-1:0]   bypass_data_r;
    logic [STATE_W-1:0]  bypass_state_r;
    logic                push_ready_s, pop_ready_s, push_acc_s, pop_acc_s;
    logic                through_s, wr_en_s, pop_rd_en_s;
    logic [ADDR_W-1:0]   wr_addr_s, pop_addr_s;
    logic [ENT_W-1:0]    pop_q_s, rd_q_s;

    // Handshake acceptance and next occupancy; clear masks both requests
    always_comb begin
        push_ready_s = (count_r < FULL_CNT);
        pop_ready_s  = (count_r != {(ADDR_W+1){1'b0}});
        push_acc_s   = bus.push_valid_i && push_ready_s && !clear_i;
        pop_acc_s    = bus.pop_req_i && pop_ready_s && !clear_i;
        count_next_s = count_r;
        if (clear_i) begin
            count_next_s = {(ADDR_W+1){1'b0}};
        end else if (push_acc_s && !pop_acc_s) begin
            count_next_s = count_r + (ADDR_W+1)'(1);
        end else if (pop_acc_s && !push_acc_s) begin
            count_next_s = count_r - (ADDR_W+1)'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    if (MODE == MODE_FIFO) begin : g_fifo
        logic [ADDR_W-1:0] head_r, tail_r;

        // Ring pointers wrap naturally at DEPTH (power of two)
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                head_r <= '0;
                tail_r <= '0;
            end else if (clear_i) begin
                head_r <= '0;
                tail_r <= '0;
            end else begin
                if (pop_acc_s)  head_r <= head_r + ADDR_W'(1);
                if (push_acc_s) tail_r <= tail_r + ADDR_W'(1);
            end
        end

        // Both ends may move in one cycle; head != tail whenever both are accepted
        always_comb begin
            wr_addr_s   = tail_r;
            pop_addr_s  = head_r;
            wr_en_s     = push_acc_s;
            pop_rd_en_s = pop_acc_s;
            through_s   = 1'b0;
        end
    end else begin : g_lifo
        // Top of stack is slot[count-1]; a concurrent push and pop short-circuits
        always_comb begin
            wr_addr_s   = count_r[ADDR_W-1:0];
            pop_addr_s  = count_r[ADDR_W-1:0] - ADDR_W'(1);
            through_s   = push_acc_s && pop_acc_s;
            wr_en_s     = push_acc_s && !pop_acc_s;
            pop_rd_en_s = pop_acc_s && !push_acc_s;
        end
    end

    inexrecur_stack_ram #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (wr_en_s),
        .wr_addr_i(wr_addr_s),
        .wr_data_i({bus.push_data_i, bus.push_state_i}),
        .a_en_i   (pop_rd_en_s),
        .a_addr_i (pop_addr_s),
        .a_data_o (pop_q_s),
        .b_en_i   (bus.rd_en_i),
        .b_addr_i (bus.rd_addr_i),
        .b_data_o (rd_q_s)
    );

    // Occupancy, high-water mark, sticky error flags and valid pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= '0;
            hwm_r       <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            pop_valid_r <= 1'b0;
            rd_valid_r  <= 1'b0;
        end else begin
            rd_valid_r <= bus.rd_en_i;
            if (clear_i) begin
                count_r     <= '0;
                hwm_r       <= '0;
                overflow_r  <= 1'b0;
                underflow_r <= 1'b0;
                pop_valid_r <= 1'b0;
            end else begin
                count_r     <= count_next_s;
                hwm_r       <= (count_next_s > hwm_r) ? count_next_s : hwm_r;
                pop_valid_r <= pop_acc_s;
                if (bus.push_valid_i && !push_ready_s) overflow_r  <= 1'b1;
                if (bus.pop_req_i && !pop_ready_s)     underflow_r <= 1'b1;
            end
        end
    end

    // Push-through capture; selection changes only on an accepted pop so the
    // pop output holds between pops (and across clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bypass_r       <= 1'b0;
            bypass_data_r  <= '0;
            bypass_state_r <= '0;
        end else if (pop_acc_s) begin
            bypass_r <= through_s;
            if (through_s) begin
                bypass_data_r  <= bus.push_data_i;
                bypass_state_r <= bus.push_state_i;
            end
        end
    end

    assign bus.push_ready_o = push_ready_s;
    assign bus.pop_ready_o  = pop_ready_s;
    assign bus.pop_valid_o  = pop_valid_r;
    assign bus.pop_data_o   = bypass_r ? bypass_data_r  : pop_q_s[ENT_W-1:STATE_W];
    assign bus.pop_state_o  = bypass_r ? bypass_state_r : pop_q_s[STATE_W-1:0];
    assign bus.rd_valid_o   = rd_valid_r;
    assign bus.rd_data_o    = rd_q_s[ENT_W-1:STATE_W];
    assign bus.rd_state_o   = rd_q_s[STATE_W-1:0];
    assign count_o          = count_r;
    assign hwm_o            = hwm_r;
    assign overflow_o       = overflow_r;
    assign underflow_o      = underflow_r;
endmodule
